// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
// Shares one Wishbone slave port between the instruction-fetch master (m0)
// and the memory-stage master (m1). One master owns the slave for a whole
// transfer. Only that owner gets the slave's ack/err. Every transfer end
// returns to IDLE for one dead cycle, so the next grant is a fresh arbitration.
// A hung slave is cut off after TIMEOUT_CYCLES granted cycles, and the owner
// then sees err.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   m0_* / m1_*              master side: cyc, stb, we, adr, sel, dat_mosi in;
//                            dat_miso, ack, err out
//   s_*                      slave side: cyc, stb, we, adr, sel, dat_mosi out;
//                            dat_miso, ack, err in
//   grant_out                one-hot {m1,m0} owner, 2'b00 when idle
//   timeout_out              single-cycle pulse when a timeout abort fires
module wishbone_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_dat_mosi,
    output logic [31:0] m0_dat_miso,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_dat_mosi,
    output logic [31:0] m1_dat_miso,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [3:0]  s_sel,
    output logic [31:0] s_dat_mosi,
    input  logic [31:0] s_dat_miso,
    input  logic        s_ack,
    input  logic        s_err,
    output logic [1:0]  grant_out,
    output logic        timeout_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam bit RR_EN = (ROUND_ROBIN != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } state_t;

    state_t           state, next_state;
    logic             last_served, next_last_served;
    logic [CNT_W-1:0] wait_cnt, next_wait_cnt;

    logic        req0, req1;
    logic        owner_is_m1;
    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_dat;
    logic [3:0]  own_sel;
    logic        resp_ack, resp_err;
    logic        tie_to_m1;

    assign req0        = m0_cyc & m0_stb;
    assign req1        = m1_cyc & m1_stb;
    assign owner_is_m1 = (state == OWN_M1);

    // Owner's request bundle. It only reaches the slave while a grant is held.
    assign own_cyc = owner_is_m1 ? m1_cyc      : m0_cyc;
    assign own_stb = owner_is_m1 ? m1_stb      : m0_stb;
    assign own_we  = owner_is_m1 ? m1_we       : m0_we;
    assign own_adr = owner_is_m1 ? m1_adr      : m0_adr;
    assign own_sel = owner_is_m1 ? m1_sel      : m0_sel;
    assign own_dat = owner_is_m1 ? m1_dat_mosi : m0_dat_mosi;

    // Read data goes to both masters. It only means something alongside ack.
    assign m0_dat_miso = s_dat_miso;
    assign m1_dat_miso = s_dat_miso;

    // Responses are steered by the registered state only. In IDLE no master
    // owns the slave, so a late ack after an abort or timeout is dropped.
    assign m0_ack = resp_ack & (state == OWN_M0);
    assign m0_err = resp_err & (state == OWN_M0);
    assign m1_ack = resp_ack & (state == OWN_M1);
    assign m1_err = resp_err & (state == OWN_M1);

    // The grant comes straight from the state register, so no master input
    // has a combinational path to it.
    assign grant_out = {state == OWN_M1, state == OWN_M0};

    // State, last-served and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= next_state;
            last_served <= next_last_served;
            wait_cnt    <= next_wait_cnt;
        end
    end

    // Arbitration, slave port routing and transfer termination. A dropped
    // cyc is treated as an abort and leaves the fairness history alone. Ack,
    // err or timeout count as real service and update it. If ack and err
    // arrive together, only err is reported.
    always_comb begin
        next_state       = state;
        next_last_served = last_served;
        next_wait_cnt    = wait_cnt;
        s_cyc            = 1'b0;
        s_stb            = 1'b0;
        s_we             = 1'b0;
        s_adr            = '0;
        s_sel            = '0;
        s_dat_mosi       = '0;
        resp_ack         = 1'b0;
        resp_err         = 1'b0;
        timeout_out      = 1'b0;
        tie_to_m1        = RR_EN ? ~last_served : 1'b1;

        case (state)
            IDLE: begin
                next_wait_cnt = '0;
                if (req0 && req1) begin
                    next_state = tie_to_m1 ? OWN_M1 : OWN_M0;
                end else if (req1) begin
                    next_state = OWN_M1;
                end else if (req0) begin
                    next_state = OWN_M0;
                end
            end
            OWN_M0, OWN_M1: begin
                s_cyc      = own_cyc;
                s_stb      = own_stb;
                s_we       = own_we;
                s_adr      = own_adr;
                s_sel      = own_sel;
                s_dat_mosi = own_dat;
                if (!own_cyc) begin
                    next_state    = IDLE;
                    next_wait_cnt = '0;
                end else if (s_ack || s_err) begin
                    resp_err         = s_err;
                    resp_ack         = s_ack & ~s_err;
                    next_state       = IDLE;
                    next_last_served = owner_is_m1;
                    next_wait_cnt    = '0;
                end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST)) begin
                    resp_err         = 1'b1;
                    timeout_out      = 1'b1;
                    next_state       = IDLE;
                    next_last_served = owner_is_m1;
                    next_wait_cnt    = '0;
                end else begin
                    next_wait_cnt = wait_cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter. The bench builds two instances:
// rr_dut (round robin, timeout of 4 cycles) and fp_dut (fixed priority, no
// timeout). Both see the same master stimulus. Each has its own slave model
// that acks a programmable number of cycles after the request is presented.
// Expected ack owners are queued when a request is driven and are popped as
// acks come out of the selected instance.
module tb_wishbone_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_mosi;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_mosi;
    logic [3:0]  m1_sel;
    logic [31:0] s_dat_miso;
    logic        force_ack, force_err;
    int          ack_lat;

    logic [31:0] rr_m0_dat_miso, rr_m1_dat_miso, rr_s_adr, rr_s_dat_mosi;
    logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
    logic        rr_s_cyc, rr_s_stb, rr_s_we, rr_s_ack, rr_timeout;
    logic [3:0]  rr_s_sel;
    logic [1:0]  rr_grant;
    int          rr_lat;

    logic [31:0] fp_m0_dat_miso, fp_m1_dat_miso, fp_s_adr, fp_s_dat_mosi;
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic        fp_s_cyc, fp_s_stb, fp_s_we, fp_s_ack, fp_timeout;
    logic [3:0]  fp_s_sel;
    logic [1:0]  fp_grant;
    int          fp_lat;

    bit          sel_fp;
    logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_s_cyc, o_timeout;
    logic [1:0]  o_grant;

    int          n_checks;
    int          n_fail;
    int          exp_q[$];

    wishbone_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) rr_dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_mosi(m0_dat_mosi), .m0_dat_miso(rr_m0_dat_miso),
        .m0_ack(rr_m0_ack), .m0_err(rr_m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_mosi(m1_dat_mosi), .m1_dat_miso(rr_m1_dat_miso),
        .m1_ack(rr_m1_ack), .m1_err(rr_m1_err),
        .s_cyc(rr_s_cyc), .s_stb(rr_s_stb), .s_we(rr_s_we), .s_adr(rr_s_adr),
        .s_sel(rr_s_sel), .s_dat_mosi(rr_s_dat_mosi), .s_dat_miso(s_dat_miso),
        .s_ack(rr_s_ack), .s_err(force_err),
        .grant_out(rr_grant), .timeout_out(rr_timeout)
    );

    wishbone_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) fp_dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_mosi(m0_dat_mosi), .m0_dat_miso(fp_m0_dat_miso),
        .m0_ack(fp_m0_ack), .m0_err(fp_m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_mosi(m1_dat_mosi), .m1_dat_miso(fp_m1_dat_miso),
        .m1_ack(fp_m1_ack), .m1_err(fp_m1_err),
        .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_adr(fp_s_adr),
        .s_sel(fp_s_sel), .s_dat_mosi(fp_s_dat_mosi), .s_dat_miso(s_dat_miso),
        .s_ack(fp_s_ack), .s_err(force_err),
        .grant_out(fp_grant), .timeout_out(fp_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Slave models: ack once the request has been presented for ack_lat
    // cycles. force_ack injects stray acks regardless of cyc.
    assign rr_s_ack = (rr_s_cyc && rr_s_stb && (rr_lat == ack_lat)) || force_ack;
    assign fp_s_ack = (fp_s_cyc && fp_s_stb && (fp_lat == ack_lat)) || force_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_lat <= 0;
            fp_lat <= 0;
        end else begin
            rr_lat <= (rr_s_cyc && rr_s_stb && !rr_s_ack) ? rr_lat + 1 : 0;
            fp_lat <= (fp_s_cyc && fp_s_stb && !fp_s_ack) ? fp_lat + 1 : 0;
        end
    end

    // Observation mux so that the same checks can run against either instance.
    assign o_m0_ack  = sel_fp ? fp_m0_ack  : rr_m0_ack;
    assign o_m1_ack  = sel_fp ? fp_m1_ack  : rr_m1_ack;
    assign o_m0_err  = sel_fp ? fp_m0_err  : rr_m0_err;
    assign o_m1_err  = sel_fp ? fp_m1_err  : rr_m1_err;
    assign o_s_cyc   = sel_fp ? fp_s_cyc   : rr_s_cyc;
    assign o_timeout = sel_fp ? fp_timeout : rr_timeout;
    assign o_grant   = sel_fp ? fp_grant   : rr_grant;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic we,
                                 input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = cyc; m0_we = we;
            m0_adr = adr; m0_sel = sel; m0_dat_mosi = dat;
        end else begin
            m1_cyc = cyc; m1_stb = cyc; m1_we = we;
            m1_adr = adr; m1_sel = sel; m1_dat_mosi = dat;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        force_ack = 1'b0;
        force_err = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Samples one negedge per cycle. Each ack pops an expected owner from the
    // queue (0 = m0, 1 = m1; 2 means both masters were acked at once).
    task automatic collectAcks(input int n, input int budget, output int got,
                               output int first_cyc, output int last_cyc);
        int who;
        int exp_who;
        got = 0;
        first_cyc = -1;
        last_cyc = -1;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (o_m0_ack || o_m1_ack) begin
                who = (o_m0_ack && !o_m1_ack) ? 0 : ((o_m1_ack && !o_m0_ack) ? 1 : 2);
                exp_who = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checkOutput("ack_owner", who, exp_who);
                if (first_cyc < 0) first_cyc = i;
                last_cyc = i;
                got++;
            end
        end
    endtask

    // Watches a stuck m0 request on the rr instance for 8 cycles. Cycle 0 is
    // the IDLE cycle in which the request first appears.
    task automatic measureTimeout(output int err_cyc, output int to_cyc,
                                  output int pulses, output int bad, output int g5);
        err_cyc = -1;
        to_cyc = -1;
        pulses = 0;
        bad = 0;
        g5 = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_m0_err && err_cyc < 0) err_cyc = i;
            if (o_timeout) begin
                pulses++;
                if (to_cyc < 0) to_cyc = i;
            end
            if (o_m1_err || o_m0_ack || o_m1_ack) bad++;
            if (i == 5) g5 = int'(o_grant);
        end
    endtask

    initial begin
        int got, first_c, last_c, extra;
        int err_c, to_c, pulses, bad, g5;

        n_checks = 0;
        n_fail = 0;
        sel_fp = 1'b0;
        ack_lat = 1000;
        s_dat_miso = 32'hCAFE_F00D;
        rst = 1'b1;
        force_ack = 1'b0;
        force_err = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Reset state
        @(negedge clk);
        checkOutput("rst_rr_grant", rr_grant, 2'b00);
        checkOutput("rst_fp_grant", fp_grant, 2'b00);
        checkOutput("rst_rr_s_cyc", rr_s_cyc, 1'b0);
        checkOutput("rst_rr_acks", {rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err}, 4'b0000);
        checkOutput("rst_rr_timeout", rr_timeout, 1'b0);

        // Single m0 request, slave acks 2 cycles after the grant
        $display("[TB] single request");
        doReset();
        ack_lat = 2;
        exp_q.push_back(0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("t1_idle_s_cyc", o_s_cyc, 1'b0);
        checkOutput("t1_idle_grant", o_grant, 2'b00);
        @(negedge clk);
        checkOutput("t1_grant", o_grant, 2'b01);
        checkOutput("t1_s_cyc", o_s_cyc, 1'b1);
        checkOutput("t1_s_adr", rr_s_adr, 32'h0000_0010);
        collectAcks(1, 6, got, first_c, last_c);
        checkOutput("t1_ack_count", got, 1);
        checkOutput("t1_ack_cycle", first_c, 1);
        checkOutput("t1_dat_miso", rr_m0_dat_miso, 32'hCAFE_F00D);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_m0_ack || o_m1_ack) extra++;
        end
        checkOutput("t1_no_extra_ack", extra, 0);
        checkOutput("t1_grant_after", o_grant, 2'b00);

        // Round robin: both masters hold cyc, slave acks on the first granted cycle
        $display("[TB] round robin alternation");
        doReset();
        ack_lat = 0;
        for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 1 : 0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        collectAcks(8, 24, got, first_c, last_c);
        checkOutput("t2_ack_count", got, 8);
        checkOutput("t2_first_cycle", first_c, 1);
        checkOutput("t2_last_cycle", last_c, 15);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Fixed priority: m1 wins every tie until it drops cyc
        $display("[TB] fixed priority");
        sel_fp = 1'b1;
        doReset();
        ack_lat = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        collectAcks(4, 12, got, first_c, last_c);
        checkOutput("t3_m1_count", got, 4);
        checkOutput("t3_m1_last", last_c, 7);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        exp_q.push_back(0);
        collectAcks(1, 6, got, first_c, last_c);
        checkOutput("t3_m0_count", got, 1);
        checkOutput("t3_m0_cycle", first_c, 1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        sel_fp = 1'b0;

        // Store pass-through from m1; m0 drives different idle values
        $display("[TB] store pass-through");
        doReset();
        ack_lat = 1;
        exp_q.push_back(1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 4'b0100, 32'h00AB_0000);
        @(negedge clk);
        checkOutput("t4_idle_we", rr_s_we, 1'b0);
        @(negedge clk);
        checkOutput("t4_grant", o_grant, 2'b10);
        checkOutput("t4_we", rr_s_we, 1'b1);
        checkOutput("t4_sel", rr_s_sel, 4'b0100);
        checkOutput("t4_dat", rr_s_dat_mosi, 32'h00AB_0000);
        checkOutput("t4_adr", rr_s_adr, 32'h0000_0200);
        collectAcks(1, 5, got, first_c, last_c);
        checkOutput("t4_ack_count", got, 1);
        checkOutput("t4_ack_cycle", first_c, 0);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Abort: m1 drops cyc while granted; a stray ack later reaches nobody
        $display("[TB] abort");
        doReset();
        ack_lat = 1000;
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_grant", o_grant, 2'b10);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t5_s_cyc_drop", o_s_cyc, 1'b0);
        @(negedge clk);
        checkOutput("t5_idle_grant", o_grant, 2'b00);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        checkOutput("t5_stray_ack", {o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 4'b0000);
        @(posedge clk); #1;
        force_ack = 1'b0;
        // The abort left last_served at m0, so m1 must win the next tie
        ack_lat = 0;
        exp_q.push_back(1);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        collectAcks(1, 4, got, first_c, last_c);
        checkOutput("t5_tie_count", got, 1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Simultaneous ack and err: the owner must see err only
        $display("[TB] ack with err");
        doReset();
        ack_lat = 1000;
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        force_ack = 1'b1;
        force_err = 1'b1;
        @(negedge clk);
        checkOutput("t6_resp", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 4'b0100);
        @(posedge clk); #1;
        force_ack = 1'b0;
        force_err = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Timeout after 4 silent granted cycles
        $display("[TB] timeout");
        doReset();
        ack_lat = 1000;
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'h0);
        measureTimeout(err_c, to_c, pulses, bad, g5);
        checkOutput("t7_err_cycle", err_c, 4);
        checkOutput("t7_timeout_cycle", to_c, 4);
        checkOutput("t7_pulses", pulses, 1);
        checkOutput("t7_other_resp", bad, 0);
        checkOutput("t7_idle_after", g5, 0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Asynchronous reset in the middle of a timeout wait
        doReset();
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("t8_grant", o_grant, 2'b00);
        checkOutput("t8_s_cyc", o_s_cyc, 1'b0);
        checkOutput("t8_resp", {o_m0_ack, o_m0_err, o_timeout}, 3'b000);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'h0);
        measureTimeout(err_c, to_c, pulses, bad, g5);
        checkOutput("t8_err_cycle_after_rst", err_c, 4);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
